passcode_controller: RTL and testbench
======================================

Name: passcode_controller

Overview:
Front-end controller that sequences the door-lock StateManager FSM.
- Turns raw keypad events into the StateManager's inputs (is_on, is_star_pressed, reset, correct, initialize).
- Buffers entered digits and owns the stored password register.
- Commits a new password on leaving the RESET state.
- Runs the lockout timer that releases the LOCK state.

Parameters:
MAX_DIGITS, 8, entry buffer / password capacity in decimal digits (4 bits each)
MIN_LEN, 4, minimum digits required for a new password in RESET state
DEFAULT_PW, 32'h0000_1234, power-up password, right-aligned BCD, length 4
LOCK_CYCLES, 1000, clk cycles spent in LOCK before auto-initialize

Ports:
clk  in  1  system clock; StateManager samples this block's outputs on negedge clk
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe: key_code is valid this cycle
key_code  in  4  0-9 digit, 10 = '*', 11 = '#', others ignored
reset_btn  in  1  password re-set button level
init_btn  in  1  initialize button level
state  in  3  current StateManager state
is_on  out  1  toggled on each '#'
is_star_pressed  out  1  one-cycle pulse per '*'
reset  out  1  registered copy of reset_btn
correct  out  1  registered comparison result
initialize  out  1  registered init_btn OR one-cycle lockout-expiry pulse
entry_len  out  4  digits currently buffered, for display

Behaviour:
State codes: OFF=000, ON=001, WRONG1=010, WRONG2=011, OPEN=100, RESET=101, LOCK=111.

Reset:
- All outputs 0; entry buffer and entry_len cleared.
- pw = DEFAULT_PW, pw_len = 4; lock timer cleared; star_pend = 0; state_prev = OFF.

Input qualification and '#':
- Keys are accepted only when key_valid = 1. Unknown codes (12-15) are ignored.
- '#': toggles is_on on the next edge, in every state except LOCK. In LOCK, '#' is ignored.

Digits:
- Accepted only in ON, WRONG1, WRONG2 and RESET.
- Shifted into the buffer LS-digit-first; entry_len increments.
- At entry_len == MAX_DIGITS further digits are dropped and the overflow flag is set.
- While the overflow flag is set, correct = 0 in ON/WRONG states.

correct (registered, one cycle after the buffer update):
- ON/WRONG1/WRONG2: 1 iff entry_len == pw_len, the buffer matches pw, and no overflow.
- RESET: 1 iff entry_len >= MIN_LEN and no overflow.
- All other states: 0.

'*' sequence, accepted in ON/WRONG1/WRONG2/RESET (ignored elsewhere):
- Edge N: star_pend set.
- Edge N+1: is_star_pressed = 1. correct is already stable because digits and '*' never share a cycle.
- Edge N+2: is_star_pressed = 0; buffer, entry_len and overflow cleared.
- While star_pend or is_star_pressed is high, new key events are ignored.

Password commit:
- On the edge where state_prev == RESET and state == OFF: pw <= buffer, pw_len <= entry_len.
- The buffer clear on that same edge uses the pre-clear values for the commit.

Other buffer clears:
- Any state change (state != state_prev) clears the buffer, except in the commit case above.
- A rising edge of initialize also clears the buffer.

Lockout (sub-module):
- While state == LOCK the timer counts up.
- At count == LOCK_CYCLES-1: initialize pulses high for 1 cycle, is_on <= 0, timer clears.
- Leaving LOCK by any other path clears the timer.

reset and initialize outputs:
- reset = reset_btn registered 1 cycle.
- initialize = registered (init_btn | expiry_pulse).
- While initialize = 1, is_on is forced to 0 so the StateManager settles in OFF.

Simultaneous events and mid-operation reset:
- rst dominates everything, including a pending star pulse; the pulse is aborted and is_star_pressed drops to 0 asynchronously.
- init_btn in the same cycle as '#': initialize wins and is_on stays 0.
- Lockout expiry and a key in the same cycle: the key is dropped (LOCK ignores keys).

Decomposition:
- Package lock_pkg: state codes (ST_OFF … ST_LOCK), key codes (KEY_STAR = 10, KEY_HASH = 11), and the digit width constant.
- Sub-module lockout_timer (clk, rst, en, expire): counter of $clog2(LOCK_CYCLES) bits with an expiry pulse.

Test Plan:
1. Default password: state=ON, keys 1,2,3,4,'*' → correct=1 from two edges after key 4; is_star_pressed high exactly 1 cycle; entry_len back to 0 afterwards.
2. Wrong code: state=WRONG1, keys 1,2,3,5,'*' → correct=0 during the pulse. Separately, 9 digits then '*' → overflow holds correct=0 and entry_len saturates at 8.
3. New password commit: state=RESET, keys 9,8,7,'*' → correct=0. Then 9,8,7,6,5,'*' and state driven to OFF → pw=98765, pw_len=5. Then in ON, 9,8,7,6,5,'*' → correct=1.
4. Lockout: state=LOCK held with LOCK_CYCLES=10 → initialize pulses on cycle 10 for 1 cycle and is_on=0. '#' pressed during LOCK → no toggle.
5. Star then state change: '*' with the state changing to OPEN on the next cycle → buffer cleared; digits in OPEN are ignored (entry_len stays 0).
6. Async reset: rst asserted mid star sequence (is_star_pressed=1) → all outputs 0 immediately and pw restored to 1234.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock front end.
// Holds the StateManager state codes, the special keypad codes, the width
// of one BCD digit, and a helper that says which states accept key entry.
package lock_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'b000,
      ST_ON     = 3'b001,
      ST_WRONG1 = 3'b010,
      ST_WRONG2 = 3'b011,
      ST_OPEN   = 3'b100,
      ST_RESET  = 3'b101,
      ST_LOCK   = 3'b111
   } state_t;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam int         DIGIT_W  = 4;

   // States in which digits and '*' are taken from the keypad.
   function automatic logic is_entry_state(input state_t s);
      return (s == ST_ON) || (s == ST_WRONG1) || (s == ST_WRONG2) || (s == ST_RESET);
   endfunction

endpackage

// File: rtl/passcode_controller_if.sv
// Bundle between the keypad/StateManager side and passcode_controller.
//   key_valid, key_code    : keypad event strobe and code
//   reset_btn, init_btn    : button levels
//   state                  : current StateManager state
//   is_on, is_star_pressed,
//   reset, correct,
//   initialize             : registered StateManager inputs
//   entry_len              : digits buffered, for display
// master drives the keypad/state side, slave is the controller.
interface passcode_controller_if;

   logic             key_valid;
   logic [3:0]       key_code;
   logic             reset_btn;
   logic             init_btn;
   lock_pkg::state_t state;

   logic             is_on;
   logic             is_star_pressed;
   logic             reset;
   logic             correct;
   logic             initialize;
   logic [3:0]       entry_len;

   modport master (
      output key_valid, key_code, reset_btn, init_btn, state,
      input  is_on, is_star_pressed, reset, correct, initialize, entry_len
   );

   modport slave (
      input  key_valid, key_code, reset_btn, init_btn, state,
      output is_on, is_star_pressed, reset, correct, initialize, entry_len
   );

endinterface

// File: rtl/lockout_timer.sv
// Counts cycles spent in LOCK and pulses expire for one cycle when the
// count reaches LOCK_CYCLES-1, then restarts from zero.
//   clk, rst : clock, async active-high reset
//   en       : high while the StateManager is in LOCK
//   expire   : one-cycle (combinational) expiry pulse
module lockout_timer #(
   parameter int LOCK_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic expire
);

   localparam int             CW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(LOCK_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign expire = en && (cnt == LAST);

   // Leaving LOCK by any path drops the count so the next lockout is full length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!en || expire)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/passcode_controller.sv
// Keypad front end for the door-lock StateManager.
// Turns keypad events into is_on / is_star_pressed / reset / correct /
// initialize, buffers entered digits, owns the stored password and runs
// the LOCK release timer.
//   clk, rst : clock, async active-high reset
//   bus      : passcode_controller_if.slave (keypad, buttons, state in;
//              StateManager inputs and entry_len out)
module passcode_controller
   import lock_pkg::*;
#(
   parameter int                              MAX_DIGITS  = 8,
   parameter int                              MIN_LEN     = 4,
   parameter logic [MAX_DIGITS*DIGIT_W-1:0]   DEFAULT_PW  = 32'h0000_1234,
   parameter int                              LOCK_CYCLES = 1000
) (
   input logic                   clk,
   input logic                   rst,
   passcode_controller_if.slave  bus
);

   localparam int         BW          = MAX_DIGITS * DIGIT_W;
   localparam logic [3:0] MAX_LEN     = 4'(MAX_DIGITS);
   localparam logic [3:0] MIN_L       = 4'(MIN_LEN);
   localparam logic [3:0] DEFAULT_LEN = 4'd4;

   logic [BW-1:0] buf_q, pw_q;
   logic [3:0]    len_q, pw_len_q;
   logic          ovf_q;
   logic          star_pend, star_q;
   logic          is_on_q, reset_q, correct_q, init_q;
   state_t        state_prev;

   logic lock_en, expire;
   logic in_entry, key_ok, dig_acc, star_acc, hash_acc;
   logic init_next, commit, clear_buf, match;

   assign lock_en = (bus.state == ST_LOCK);

   lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lockout_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (lock_en),
      .expire (expire)
   );

   always_comb begin
      in_entry  = is_entry_state(bus.state);
      // Keys are frozen while a '*' pulse is in flight so correct stays put.
      key_ok    = bus.key_valid && !star_pend && !star_q;
      dig_acc   = key_ok && (bus.key_code <= 4'd9) && in_entry;
      star_acc  = key_ok && (bus.key_code == KEY_STAR) && in_entry;
      hash_acc  = key_ok && (bus.key_code == KEY_HASH) && !lock_en;
      init_next = bus.init_btn || expire;
      commit    = (state_prev == ST_RESET) && (bus.state == ST_OFF);
      // Clear once the '*' pulse is done, on any state change, or as
      // initialize rises.
      clear_buf = star_q || (bus.state != state_prev) || (init_next && !init_q);
      match     = (len_q == pw_len_q) && (buf_q == pw_q) && !ovf_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q      <= '0;
         len_q      <= '0;
         ovf_q      <= 1'b0;
         pw_q       <= DEFAULT_PW;
         pw_len_q   <= DEFAULT_LEN;
         star_pend  <= 1'b0;
         star_q     <= 1'b0;
         is_on_q    <= 1'b0;
         reset_q    <= 1'b0;
         correct_q  <= 1'b0;
         init_q     <= 1'b0;
         state_prev <= ST_OFF;
      end else begin
         state_prev <= bus.state;
         reset_q    <= bus.reset_btn;
         init_q     <= init_next;
         star_pend  <= star_acc;
         star_q     <= star_pend;

         case (bus.state)
            ST_ON, ST_WRONG1, ST_WRONG2: correct_q <= match;
            ST_RESET:                    correct_q <= (len_q >= MIN_L) && !ovf_q;
            default:                     correct_q <= 1'b0;
         endcase

         // initialize holds the StateManager in OFF, so it beats a '#'.
         if (init_next)
            is_on_q <= 1'b0;
         else if (hash_acc)
            is_on_q <= ~is_on_q;

         // Commit samples the buffer before this edge's clear.
         if (commit) begin
            pw_q     <= buf_q;
            pw_len_q <= len_q;
         end

         if (clear_buf) begin
            buf_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
         end else if (dig_acc) begin
            if (len_q == MAX_LEN)
               ovf_q <= 1'b1;
            else begin
               buf_q <= {buf_q[BW-DIGIT_W-1:0], bus.key_code};
               len_q <= len_q + 4'd1;
            end
         end
      end
   end

   assign bus.is_on           = is_on_q;
   assign bus.is_star_pressed = star_q;
   assign bus.reset           = reset_q;
   assign bus.correct         = correct_q;
   assign bus.initialize      = init_q;
   assign bus.entry_len       = len_q;

endmodule

// File: tb/tb_passcode_controller.sv
module tb_passcode_controller;
   import lock_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   passcode_controller_if bus ();

   passcode_controller #(.LOCK_CYCLES(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { int c; int len; } exp_t;
   exp_t sbq[$];
   exp_t e;

   // Reference model: digit sequences as plain queues.
   int     digits[$];
   int     pw[$];
   bit     ovf;
   bit     m_on;
   state_t cur;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit m_entry();
      return cur == ST_ON || cur == ST_WRONG1 || cur == ST_WRONG2 || cur == ST_RESET;
   endfunction

   function automatic bit m_pw_match();
      if (digits.size() != pw.size()) return 0;
      foreach (pw[i]) if (digits[i] != pw[i]) return 0;
      return 1;
   endfunction

   function automatic void m_set_state(input state_t s);
      if (s != cur) begin
         if (cur == ST_RESET && s == ST_OFF) pw = digits;
         digits.delete();
         ovf = 0;
      end
      cur = s;
   endfunction

   function automatic void m_key(input int code);
      exp_t x;
      if (code <= 9) begin
         if (m_entry()) begin
            if (digits.size() == 8) ovf = 1;
            else digits.push_back(code);
         end
      end else if (code == 11) begin
         if (cur != ST_LOCK) m_on = !m_on;
      end else if (code == 10 && m_entry()) begin
         if (cur == ST_RESET) x.c = (digits.size() >= 4 && !ovf) ? 1 : 0;
         else                 x.c = (m_pw_match() && !ovf) ? 1 : 0;
         x.len = digits.size();
         sbq.push_back(x);
      end
   endfunction

   function automatic void m_reset();
      digits.delete();
      pw = '{1, 2, 3, 4};
      ovf = 0; m_on = 0; cur = ST_OFF;
   endfunction

   task automatic press(input logic [3:0] code);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      @(negedge clk);
      bus.key_valid = 1'b0;
      m_key(int'(code));
      if (code != KEY_STAR) begin
         check("entry_len", bus.entry_len, digits.size());
         check("is_on", bus.is_on, m_on);
      end
   endtask

   task automatic set_state(input state_t s);
      @(negedge clk);
      bus.state = s;
      m_set_state(s);
   endtask

   // '*', then optionally move to another state while the pulse is high.
   task automatic star(input state_t after);
      bit acc;
      acc = m_entry();
      press(KEY_STAR);
      @(negedge clk);
      if (after != cur) begin
         bus.state = after;
         m_set_state(after);
      end
      if (acc) begin digits.delete(); ovf = 0; end
      repeat (2) @(negedge clk);
      check("entry_len_after_star", bus.entry_len, digits.size());
      check("star_low", bus.is_star_pressed, 0);
   endtask

   task automatic press_seq(input int n, input int base);
      for (int i = 0; i < n; i++) press(4'((base + i) % 10));
   endtask

   // Scoreboard monitor: one expected entry per high cycle of is_star_pressed.
   always @(negedge clk) begin
      if (!rst && bus.is_star_pressed) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL star_pulse: got unexpected pulse, expected none");
         end else begin
            e = sbq.pop_front();
            check("star_correct", bus.correct, e.c);
            check("star_len", bus.entry_len, e.len);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      state_t picks[4];
      state_t st;
      int     n;
      int     pwc[$];
      picks = '{ST_ON, ST_WRONG1, ST_WRONG2, ST_RESET};

      rst = 1'b1;
      bus.key_valid = 1'b0; bus.key_code = 4'd0;
      bus.reset_btn = 1'b0; bus.init_btn = 1'b0;
      bus.state = ST_OFF;
      m_reset();
      repeat (2) @(negedge clk);
      check("rst_is_on", bus.is_on, 0);
      check("rst_star", bus.is_star_pressed, 0);
      check("rst_reset", bus.reset, 0);
      check("rst_correct", bus.correct, 0);
      check("rst_init", bus.initialize, 0);
      check("rst_len", bus.entry_len, 0);
      rst = 1'b0;

      // reset_btn is a one-cycle registered copy
      @(negedge clk); bus.reset_btn = 1'b1;
      @(negedge clk); check("reset_out_hi", bus.reset, 1); bus.reset_btn = 1'b0;
      @(negedge clk); check("reset_out_lo", bus.reset, 0);

      // 1: default password
      set_state(ST_ON);
      press_seq(4, 1);
      @(negedge clk);
      check("default_correct", bus.correct, 1);
      star(ST_ON);

      // 2: wrong code, then overflow
      set_state(ST_WRONG1);
      press(1); press(2); press(3); press(5);
      star(ST_WRONG1);
      press_seq(9, 1);
      check("ovf_len", bus.entry_len, 8);
      star(ST_WRONG1);

      // 3: new password commit
      set_state(ST_RESET);
      press(9); press(8); press(7);
      star(ST_RESET);
      press(9); press(8); press(7); press(6); press(5);
      star(ST_OFF);
      set_state(ST_ON);
      press(9); press(8); press(7); press(6); press(5);
      star(ST_ON);
      // full-length password, then the same digits plus one overflowing
      set_state(ST_RESET);
      press_seq(8, 1);
      star(ST_OFF);
      set_state(ST_ON);
      press_seq(8, 1);
      star(ST_ON);
      press_seq(9, 1);
      star(ST_ON);

      // 4: lockout with '#' ignored and a key dropped at expiry
      press(KEY_HASH);
      set_state(ST_LOCK);
      for (int c = 1; c <= 11; c++) begin
         if (c == 3)  begin bus.key_valid = 1'b1; bus.key_code = KEY_HASH; end
         if (c == 10) begin bus.key_valid = 1'b1; bus.key_code = 4'd5; end
         @(negedge clk);
         bus.key_valid = 1'b0;
         check("lock_initialize", bus.initialize, (c == 10) ? 1 : 0);
         check("lock_is_on", bus.is_on, (c < 10) ? 1 : 0);
      end
      check("lock_len", bus.entry_len, 0);
      m_on = 0;
      set_state(ST_OFF);

      // init_btn together with '#': initialize wins, buffer cleared
      set_state(ST_ON);
      press(1); press(2);
      @(negedge clk);
      bus.init_btn = 1'b1; bus.key_valid = 1'b1; bus.key_code = KEY_HASH;
      @(negedge clk);
      bus.key_valid = 1'b0;
      digits.delete(); ovf = 0; m_on = 0;
      check("init_hi", bus.initialize, 1);
      check("init_is_on", bus.is_on, 0);
      check("init_len", bus.entry_len, 0);
      @(negedge clk); bus.init_btn = 1'b0;
      @(negedge clk);
      check("init_lo", bus.initialize, 0);
      check("init_is_on_after", bus.is_on, 0);

      // 5: star then move to OPEN; OPEN ignores digits and '*'
      press(1); press(2);
      star(ST_OPEN);
      press(5); press(6);
      star(ST_OPEN);

      // random entry rounds
      for (int it = 0; it < 30; it++) begin
         st = picks[$urandom_range(0, 3)];
         set_state(st);
         if ($urandom_range(0, 2) == 0) begin
            pwc = pw;
            foreach (pwc[i]) press(4'(pwc[i]));
         end else begin
            n = $urandom_range(0, 9);
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(0, 5) == 0) press(4'($urandom_range(12, 15)));
               press(4'($urandom_range(0, 9)));
            end
         end
         if ($urandom_range(0, 3) == 0) press(KEY_HASH);
         star(st);
      end

      // 6: async reset mid star pulse restores the default password
      set_state(ST_ON);
      if (!m_on) press(KEY_HASH);
      pwc = pw;
      foreach (pwc[i]) press(4'(pwc[i]));
      press(KEY_STAR);
      @(negedge clk);
      #2 rst = 1'b1;
      bus.state = ST_OFF;
      m_reset();
      #1;
      check("arst_is_on", bus.is_on, 0);
      check("arst_star", bus.is_star_pressed, 0);
      check("arst_correct", bus.correct, 0);
      check("arst_len", bus.entry_len, 0);
      check("arst_init", bus.initialize, 0);
      check("arst_reset", bus.reset, 0);
      @(negedge clk);
      rst = 1'b0;
      set_state(ST_ON);
      press_seq(4, 1);
      star(ST_ON);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
